cpu_hazard_scoreboard: RTL and testbench
========================================

// Module: cpu_hazard_scoreboard
// PURPOSE
//  Hazard detection unit: drives the HDU slave side (stall) consumed by fetch and decode.
//  Detects load-use hazards against the load currently in execute.
//  Also keeps a per-register pending-load scoreboard, so variable-latency loads
//  (memory stall / cache miss) hold dependants in decode until writeback.
//  Sits between the execute/mem/writeback stages and the fetch/decode stall inputs.
// PARAMETERS
//  NUM_REGS   32   architectural registers (from CPU_define); REG_W = $clog2(NUM_REGS)
//  CNT_W      32   width of the saturating stall performance counter
// PORTS
//  clk               in   1       core clock, all state on posedge
//  rst_n             in   1       asynchronous active-low reset
//  execute_valid     in   1       execute holds a real instruction (not a bubble)
//  execute_mem_read  in   1       instruction in execute is a load
//  execute_rd        in   REG_W   destination of instruction in execute
//  decode_ra         in   REG_W   source A of instruction in decode
//  ra_use            in   1       decode reads ra
//  decode_rb         in   REG_W   source B of instruction in decode
//  rb_use            in   1       decode reads rb
//  mem_busy          in   1       mem stage is not accepting (miss); pipeline frozen
//  wb_load_done      in   1       a load result is written this cycle
//  wb_rd             in   REG_W   register written by that load
//  stall             out  1       freeze fetch/decode, insert bubble into execute
//  pending_any       out  1       at least one scoreboard bit set
//  sb_error          out  1       sticky: wb_load_done for a non-pending register
//  stall_cycles      out  CNT_W   saturating count of cycles with stall=1
// BEHAVIOUR
//  Reset (rst_n low, async): scoreboard cleared; stall=0, pending_any=0,
//    sb_error=0, stall_cycles=0. stall is forced 0 while rst_n is low.
//  Register 0 is never a hazard source and is never marked pending.
//  Definitions:
//    ld_hit(r) = execute_valid & execute_mem_read & (execute_rd==r) & (r!=0)
//    sb_hit(r) = pending[r] & ~(wb_load_done & wb_rd==r), i.e. same-cycle writeback bypasses.
//  stall (combinational, 0-cycle latency):
//    (ra_use & (ld_hit(ra)|sb_hit(ra))) | (rb_use & (ld_hit(rb)|sb_hit(rb))) | mem_busy.
//  Scoreboard update (posedge):
//    - Load advances out of execute when execute_valid & execute_mem_read & ~mem_busy
//      & execute_rd!=0. On that edge, set pending[execute_rd].
//    - wb_load_done clears pending[wb_rd].
//    - Simultaneous set and clear of the same register: set wins (newer load).
//    - While mem_busy=1: no set. Clears from writeback still apply.
//  sb_error: set when wb_load_done & wb_rd!=0 & ~pending[wb_rd]; cleared only by reset.
//  pending_any = |pending (registered state, not inputs).
//  stall_cycles: +1 each cycle stall=1; holds at all-ones (no wrap).
//  Decode-stall bubble: the execute instruction still advances during a load-use stall.
//    The next cycle therefore sees execute_valid=0; the dependency then comes from the scoreboard.
// TESTING
//  1 Load r5 in execute, decode uses ra=r5 ra_use=1 -> stall=1 same cycle.
//    Next cycle pending[5]=1 -> stall held until wb_load_done wb_rd=5.
//    That cycle stall=0 (bypass); stall_cycles increments by the stall length.
//  2 Decode uses r0 while a load to r0 is in execute -> stall=0; pending_any stays 0.
//  3 mem_busy=1 for 4 cycles with a load r7 in execute -> stall=1 all 4 cycles;
//    pending[7] set only on the edge after mem_busy drops.
//  4 pending[3]=1; on the same edge, new load r3 advances and wb_load_done wb_rd=3
//    -> pending[3] stays 1; decode ra=r3 still stalls.
//  5 wb_load_done wb_rd=9 with pending[9]=0 -> sb_error=1 next cycle, sticky until rst_n low.
//  6 Assert rst_n low mid-stall with pending bits set -> stall, pending_any, sb_error
//    and stall_cycles all 0 immediately (async); rb_use hazard on r4 after release
//    -> normal detection.

Source files
------------

// File: rtl/cpu_hazard_scoreboard.sv
// Hazard detection unit: load-use detection against execute plus a per-register
// pending-load scoreboard that holds dependants in decode until the load writes back.
module cpu_hazard_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned REG_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             execute_valid,
    input  logic             execute_mem_read,
    input  logic [REG_W-1:0] execute_rd,
    input  logic [REG_W-1:0] decode_ra,
    input  logic             ra_use,
    input  logic [REG_W-1:0] decode_rb,
    input  logic             rb_use,
    input  logic             mem_busy,
    input  logic             wb_load_done,
    input  logic [REG_W-1:0] wb_rd,
    output logic             stall,
    output logic             pending_any,
    output logic             sb_error,
    output logic [CNT_W-1:0] stall_cycles
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                sb_error_q, sb_error_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic ld_in_ex;
    logic ld_advance;
    logic ld_hit_a, ld_hit_b;
    logic sb_hit_a, sb_hit_b;
    logic hazard;

    // Hazard terms; a same-cycle writeback of the source register bypasses the scoreboard.
    always_comb begin
        ld_in_ex   = execute_valid & execute_mem_read & (execute_rd != '0);
        ld_advance = ld_in_ex & ~mem_busy;
        ld_hit_a   = ld_in_ex & (execute_rd == decode_ra);
        ld_hit_b   = ld_in_ex & (execute_rd == decode_rb);
        sb_hit_a   = pending_q[decode_ra] & ~(wb_load_done & (wb_rd == decode_ra));
        sb_hit_b   = pending_q[decode_rb] & ~(wb_load_done & (wb_rd == decode_rb));
        hazard     = (ra_use & (ld_hit_a | sb_hit_a)) |
                     (rb_use & (ld_hit_b | sb_hit_b)) |
                     mem_busy;
        // Stall is held low during reset regardless of inputs.
        stall      = rst_n & hazard;
    end

    // Scoreboard next state: clear on writeback first so a newer load's set wins.
    always_comb begin
        pending_d = pending_q;
        if (wb_load_done) begin
            pending_d[wb_rd] = 1'b0;
        end
        if (ld_advance) begin
            pending_d[execute_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Sticky error for a writeback to a register that had no outstanding load.
    always_comb begin
        sb_error_d = sb_error_q;
        if (wb_load_done && (wb_rd != '0) && !pending_q[wb_rd]) begin
            sb_error_d = 1'b1;
        end
    end

    // Saturating stall-cycle counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            sb_error_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            pending_q   <= pending_d;
            sb_error_q  <= sb_error_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Registered status outputs.
    always_comb begin
        pending_any  = |pending_q;
        sb_error     = sb_error_q;
        stall_cycles = stall_cnt_q;
    end

endmodule

// File: tb/tb_cpu_hazard_scoreboard.sv
// Directed self-checking bench for cpu_hazard_scoreboard.
module tb_cpu_hazard_scoreboard;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned REG_W    = 5;

    logic             clk;
    logic             rst_n;
    logic             execute_valid;
    logic             execute_mem_read;
    logic [REG_W-1:0] execute_rd;
    logic [REG_W-1:0] decode_ra;
    logic             ra_use;
    logic [REG_W-1:0] decode_rb;
    logic             rb_use;
    logic             mem_busy;
    logic             wb_load_done;
    logic [REG_W-1:0] wb_rd;
    logic             stall;
    logic             pending_any;
    logic             sb_error;
    logic [CNT_W-1:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    cpu_hazard_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .execute_valid    (execute_valid),
        .execute_mem_read (execute_mem_read),
        .execute_rd       (execute_rd),
        .decode_ra        (decode_ra),
        .ra_use           (ra_use),
        .decode_rb        (decode_rb),
        .rb_use           (rb_use),
        .mem_busy         (mem_busy),
        .wb_load_done     (wb_load_done),
        .wb_rd            (wb_rd),
        .stall            (stall),
        .pending_any      (pending_any),
        .sb_error         (sb_error),
        .stall_cycles     (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        execute_valid    = 1'b0;
        execute_mem_read = 1'b0;
        execute_rd       = '0;
        decode_ra        = '0;
        ra_use           = 1'b0;
        decode_rb        = '0;
        rb_use           = 1'b0;
        mem_busy         = 1'b0;
        wb_load_done     = 1'b0;
        wb_rd            = '0;
    endtask

    task automatic load_in_ex(input logic [REG_W-1:0] rd);
        execute_valid    = 1'b1;
        execute_mem_read = 1'b1;
        execute_rd       = rd;
    endtask

    // Inputs change on negedge; checks run 1 time unit later, well clear of posedge.
    task automatic next_cyc();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #12;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_pending_any", 32'(pending_any), 32'd0);
        check("reset_sb_error", 32'(sb_error), 32'd0);
        check("reset_stall_cycles", stall_cycles, 32'd0);
        next_cyc();
        rst_n = 1'b1;

        // 1: load-use on ra, then scoreboard hold, then writeback bypass.
        next_cyc();
        load_in_ex(5'd5);
        decode_ra = 5'd5;
        ra_use    = 1'b1;
        #1 check("t1_ld_use_stall", 32'(stall), 32'd1);
        next_cyc();
        idle_inputs();
        decode_ra = 5'd5;
        ra_use    = 1'b1;
        #1 check("t1_sb_stall", 32'(stall), 32'd1);
        check("t1_pending_any", 32'(pending_any), 32'd1);
        check("t1_cnt_mid", stall_cycles, 32'd1);
        next_cyc();
        wb_load_done = 1'b1;
        wb_rd        = 5'd5;
        #1 check("t1_bypass_nostall", 32'(stall), 32'd0);
        check("t1_cnt_after2", stall_cycles, 32'd2);
        next_cyc();
        idle_inputs();
        #1 check("t1_pending_cleared", 32'(pending_any), 32'd0);
        check("t1_no_error", 32'(sb_error), 32'd0);
        check("t1_cnt_final", stall_cycles, 32'd2);

        // 2: r0 is never a hazard nor pending.
        next_cyc();
        load_in_ex(5'd0);
        decode_ra = 5'd0;
        ra_use    = 1'b1;
        decode_rb = 5'd0;
        rb_use    = 1'b1;
        #1 check("t2_r0_nostall", 32'(stall), 32'd0);
        next_cyc();
        idle_inputs();
        #1 check("t2_r0_not_pending", 32'(pending_any), 32'd0);
        check("t2_cnt", stall_cycles, 32'd2);

        // 3: mem_busy freezes; load r7 only recorded after busy drops.
        for (int k = 0; k < 4; k++) begin
            next_cyc();
            load_in_ex(5'd7);
            mem_busy = 1'b1;
            #1 check($sformatf("t3_busy_stall%0d", k), 32'(stall), 32'd1);
            check($sformatf("t3_busy_nopend%0d", k), 32'(pending_any), 32'd0);
        end
        next_cyc();
        mem_busy = 1'b0;
        #1 check("t3_release_nostall", 32'(stall), 32'd0);
        check("t3_release_nopend", 32'(pending_any), 32'd0);
        check("t3_cnt", stall_cycles, 32'd6);
        next_cyc();
        idle_inputs();
        #1 check("t3_pend_set", 32'(pending_any), 32'd1);
        decode_ra = 5'd7;
        ra_use    = 1'b1;
        #1 check("t3_dep_stall", 32'(stall), 32'd1);
        next_cyc();
        ra_use       = 1'b0;
        wb_load_done = 1'b1;
        wb_rd        = 5'd7;
        next_cyc();
        idle_inputs();
        #1 check("t3_pend_clear", 32'(pending_any), 32'd0);
        check("t3_cnt_final", stall_cycles, 32'd7);

        // 4: set and clear of r3 on the same edge: set wins.
        next_cyc();
        load_in_ex(5'd3);
        next_cyc();
        load_in_ex(5'd3);
        wb_load_done = 1'b1;
        wb_rd        = 5'd3;
        decode_ra    = 5'd3;
        ra_use       = 1'b1;
        #1 check("t4_same_edge_stall", 32'(stall), 32'd1);
        next_cyc();
        idle_inputs();
        decode_ra = 5'd3;
        ra_use    = 1'b1;
        #1 check("t4_set_wins_stall", 32'(stall), 32'd1);
        check("t4_set_wins_pend", 32'(pending_any), 32'd1);
        check("t4_cnt", stall_cycles, 32'd8);
        next_cyc();
        ra_use       = 1'b0;
        wb_load_done = 1'b1;
        wb_rd        = 5'd3;
        next_cyc();
        idle_inputs();
        #1 check("t4_pend_clear", 32'(pending_any), 32'd0);
        check("t4_no_error", 32'(sb_error), 32'd0);
        check("t4_cnt_final", stall_cycles, 32'd9);

        // 5: writeback to non-pending r9 raises sticky error.
        next_cyc();
        wb_load_done = 1'b1;
        wb_rd        = 5'd9;
        #1 check("t5_err_not_yet", 32'(sb_error), 32'd0);
        next_cyc();
        idle_inputs();
        #1 check("t5_err_set", 32'(sb_error), 32'd1);
        next_cyc();
        next_cyc();
        #1 check("t5_err_sticky", 32'(sb_error), 32'd1);

        // 6: async reset mid-stall, then rb hazard on r4.
        next_cyc();
        load_in_ex(5'd10);
        decode_ra = 5'd10;
        ra_use    = 1'b1;
        next_cyc();
        execute_valid = 1'b0;
        #1 check("t6_pre_stall", 32'(stall), 32'd1);
        check("t6_pre_pend", 32'(pending_any), 32'd1);
        check("t6_pre_cnt", stall_cycles, 32'd10);
        rst_n = 1'b0;
        #1 check("t6_rst_stall", 32'(stall), 32'd0);
        check("t6_rst_pend", 32'(pending_any), 32'd0);
        check("t6_rst_err", 32'(sb_error), 32'd0);
        check("t6_rst_cnt", stall_cycles, 32'd0);
        next_cyc();
        rst_n = 1'b1;
        #1 check("t6_post_nostall", 32'(stall), 32'd0);
        next_cyc();
        idle_inputs();
        load_in_ex(5'd4);
        decode_rb = 5'd4;
        rb_use    = 1'b1;
        #1 check("t6_rb_ld_stall", 32'(stall), 32'd1);
        next_cyc();
        execute_valid = 1'b0;
        #1 check("t6_rb_sb_stall", 32'(stall), 32'd1);
        check("t6_rb_cnt", stall_cycles, 32'd1);
        rb_use = 1'b0;
        #1 check("t6_rb_unused", 32'(stall), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
